clint_slave: RTL
================

CLINT_SLAVE -- requirements
Module: clint_slave

Interface
REQ-001 The block SHALL have parameter MTIME_ADDR, default 64'h0200_BFF8, giving the byte address of mtime.
REQ-002 The block SHALL have parameter MTIMECMP_ADDR, default 64'h0200_4000, giving the byte address of mtimecmp.
REQ-003 The block SHALL have parameter TICK_DIV, default 1, giving core clocks per mtime increment (range 1..65535).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 clint_valid_i  in  1  request valid, held by the initiator until clint_ready_o.
REQ-007 clint_req_i  in  1  1 = write, 0 = read.
REQ-008 clint_addr_i  in  64  byte address.
REQ-009 clint_size_i  in  2  00 byte, 01 half, 10 word, 11 dword.
REQ-010 clint_data_write_i  in  64  write data, little-endian, in the low 2^size bytes.
REQ-011 clint_ready_o  out  1  one-cycle completion pulse.
REQ-012 clint_data_read_o  out  64  read data, valid only while clint_ready_o=1, 0 otherwise.
REQ-013 clint_resp_o  out  2  00 OKAY, 10 SLVERR; valid only while clint_ready_o=1.
REQ-014 clint_timer_int_o  out  1  machine timer interrupt level.

Function
REQ-015 The FSM SHALL have two states: IDLE and RESP.
REQ-016 IDLE->RESP SHALL occur when clint_valid_i=1; address, size, req and data are captured that cycle, and any write is committed that same edge.
REQ-017 RESP SHALL assert clint_ready_o=1 for exactly one cycle, then return to IDLE unconditionally; request-to-ready latency is 1 cycle.
REQ-018 clint_valid_i seen in RESP SHALL be ignored; the next request is accepted in IDLE, giving at most one transaction per 2 cycles.
REQ-019 Reads SHALL return the full 64-bit register value sampled at the capture edge, independent of size.
REQ-020 Writes SHALL replace bytes [2^size-1:0] of the target register and preserve the upper bytes.
REQ-021 An address not equal to a mapped register SHALL produce resp=10 and read data 0, and SHALL write nothing.
REQ-022 A 16-bit prescaler SHALL count 0..TICK_DIV-1; mtime SHALL increment by 1 each time the prescaler wraps, and SHALL wrap from 2^64-1 to 0.
REQ-023 A write to mtime in the same cycle as a tick SHALL take precedence (the written value is kept and the tick is lost), and SHALL clear the prescaler.
REQ-024 clint_timer_int_o SHALL be registered and equal (mtime >= mtimecmp, unsigned) evaluated on the previous cycle's values.
REQ-025 Writing mtimecmp above mtime SHALL deassert the interrupt on the second edge after the write.

Reset
REQ-026 On rst_n=0 at a clock edge: state=IDLE, mtime=0, prescaler=0, mtimecmp=all-ones, all outputs 0.
REQ-027 Reset asserted while in RESP SHALL abort the response (no ready pulse) and discard any pending state.

Configuration
REQ-028 With CLINT_MSIP_EN defined, the block SHALL add parameter MSIP_ADDR (default 64'h0200_0000), a 1-bit msip register (bit 0 writable, reads zero-extended, reset 0), and output clint_soft_int_o = msip.
REQ-029 Without CLINT_MSIP_EN, MSIP_ADDR SHALL be unmapped (SLVERR) and clint_soft_int_o SHALL not exist.

Structure
REQ-030 The address constants, response codes (RESP_OKAY, RESP_SLVERR) and size encodings SHALL live in the shared defines file.
REQ-031 The mtime/prescaler logic SHALL be a sub-module, clint_mtime_cnt, with inputs tick-enable, write-enable, write-data and output mtime.

Verification
REQ-032 After reset, read MTIMECMP_ADDR with size 11 -> ready at cycle+1, data 64'hFFFF_FFFF_FFFF_FFFF, resp 00, int 0.
REQ-033 TICK_DIV=4: write mtime=10, idle 8 cycles, then read -> 12.
REQ-034 Write mtime=2^64-2 with TICK_DIV=1, then wait -> value wraps to 0; with mtimecmp=5, int asserts one cycle after mtime reaches 5.
REQ-035 mtimecmp=64'h1122_3344_5566_7788, then write size 00 data 8'hAA -> read back 64'h1122_3344_5566_77AA.
REQ-036 Read address 64'h0200_0008 -> resp 10, data 0, no register changes; valid held for 3 cycles -> exactly one ready pulse.
REQ-037 Assert rst_n=0 in the RESP cycle -> no ready pulse, and all registers at their reset values.

Source files
------------

// File: rtl/clint_slave_pkg.sv
// clint_slave_pkg -- shared constants for the CLINT slave.
//   Default register byte addresses, response codes, access size encodings
//   and the byte-lane merge helper used for partial writes.
package clint_slave_pkg;

  localparam logic [63:0] MTIME_ADDR_DEF    = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] MTIMECMP_ADDR_DEF = 64'h0000_0000_0200_4000;
  localparam logic [63:0] MSIP_ADDR_DEF     = 64'h0000_0000_0200_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_DWORD = 2'b11;

  // Replace the low 2^size bytes of old_v with those of new_v.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [1:0]  size);
    logic [63:0] mask;
    case (size)
      SIZE_BYTE: mask = 64'h0000_0000_0000_00FF;
      SIZE_HALF: mask = 64'h0000_0000_0000_FFFF;
      SIZE_WORD: mask = 64'h0000_0000_FFFF_FFFF;
      default:   mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return (old_v & ~mask) | (new_v & mask);
  endfunction

endpackage

// File: rtl/clint_mtime_cnt.sv
// clint_mtime_cnt -- prescaled 64-bit machine timer.
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset (mtime=0, prescaler=0)
//   tick_en_i  : prescaler count enable
//   wr_en_i    : load mtime from wr_data_i (wins over a same-cycle tick)
//   wr_data_i  : value to load
//   mtime_o    : current mtime
module clint_mtime_cnt #(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_en_i,
  input  logic        wr_en_i,
  input  logic [63:0] wr_data_i,
  output logic [63:0] mtime_o
);

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;

  always_comb begin
    presc_d = presc_q;
    mtime_d = mtime_q;
    if (wr_en_i) begin
      // A software write drops any tick due this cycle and restarts the period.
      mtime_d = wr_data_i;
      presc_d = '0;
    end else if (tick_en_i) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime_o = mtime_q;

endmodule

// File: rtl/clint_slave.sv
// clint_slave -- core-local interruptor slave (mtime / mtimecmp timer).
//   Ports:
//     clk, rst_n             : clock, synchronous active-low reset
//     clint_valid_i          : request valid (held until clint_ready_o)
//     clint_req_i            : 1 = write, 0 = read
//     clint_addr_i           : byte address
//     clint_size_i           : access size (byte/half/word/dword)
//     clint_data_write_i     : write data, little-endian in low bytes
//     clint_ready_o          : one-cycle completion pulse
//     clint_data_read_o      : read data, zero outside the ready cycle
//     clint_resp_o           : OKAY / SLVERR, zero outside the ready cycle
//     clint_timer_int_o      : registered mtime >= mtimecmp
//     clint_soft_int_o       : msip bit (only with CLINT_MSIP_EN)
//   Build option: define CLINT_MSIP_EN to map the msip register at MSIP_ADDR.
module clint_slave
  import clint_slave_pkg::*;
#(
  parameter logic [63:0] MTIME_ADDR    = MTIME_ADDR_DEF,
  parameter logic [63:0] MTIMECMP_ADDR = MTIMECMP_ADDR_DEF,
`ifdef CLINT_MSIP_EN
  parameter logic [63:0] MSIP_ADDR     = MSIP_ADDR_DEF,
`endif
  parameter int          TICK_DIV      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clint_valid_i,
  input  logic        clint_req_i,
  input  logic [63:0] clint_addr_i,
  input  logic [1:0]  clint_size_i,
  input  logic [63:0] clint_data_write_i,
  output logic        clint_ready_o,
  output logic [63:0] clint_data_read_o,
  output logic [1:0]  clint_resp_o,
`ifdef CLINT_MSIP_EN
  output logic        clint_soft_int_o,
`endif
  output logic        clint_timer_int_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  resp_q, resp_d;
  logic        tint_q, tint_d;
  logic [63:0] mtime;
  logic        accept, hit_mtime, hit_cmp, hit_msip, mapped;
  logic        wr_mtime, wr_cmp;
  logic [63:0] rsel;

  assign accept    = (state_q == ST_IDLE) && clint_valid_i;
  assign hit_mtime = (clint_addr_i == MTIME_ADDR);
  assign hit_cmp   = (clint_addr_i == MTIMECMP_ADDR);
`ifdef CLINT_MSIP_EN
  logic msip_q, msip_d;
  assign hit_msip  = (clint_addr_i == MSIP_ADDR);
`else
  assign hit_msip  = 1'b0;
`endif
  assign mapped    = hit_mtime | hit_cmp | hit_msip;
  assign wr_mtime  = accept && clint_req_i && hit_mtime;
  assign wr_cmp    = accept && clint_req_i && hit_cmp;

  clint_mtime_cnt #(
    .TICK_DIV (TICK_DIV)
  ) u_mtime_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_en_i (1'b1),
    .wr_en_i   (wr_mtime),
    .wr_data_i (merge_bytes(mtime, clint_data_write_i, clint_size_i)),
    .mtime_o   (mtime)
  );

  always_comb begin
    rsel = '0;
    if (hit_mtime)    rsel = mtime;
    else if (hit_cmp) rsel = mtimecmp_q;
`ifdef CLINT_MSIP_EN
    else if (hit_msip) rsel = {63'd0, msip_q};
`endif
  end

  always_comb begin
    state_d    = state_q;
    mtimecmp_d = wr_cmp ? merge_bytes(mtimecmp_q, clint_data_write_i, clint_size_i)
                        : mtimecmp_q;
    rdata_d    = rdata_q;
    resp_d     = resp_q;
    // Compare uses the values held before this edge, so the level lags by one.
    tint_d     = (mtime >= mtimecmp_q);
    case (state_q)
      ST_IDLE: begin
        if (clint_valid_i) begin
          state_d = ST_RESP;
          rdata_d = (mapped && !clint_req_i) ? rsel : 64'd0;
          resp_d  = mapped ? RESP_OKAY : RESP_SLVERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CLINT_MSIP_EN
  always_comb begin
    msip_d = msip_q;
    if (accept && clint_req_i && hit_msip) msip_d = clint_data_write_i[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) msip_q <= 1'b0;
    else        msip_q <= msip_d;
  end

  assign clint_soft_int_o = msip_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mtimecmp_q <= '1;
      rdata_q    <= '0;
      resp_q     <= RESP_OKAY;
      tint_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
      tint_q     <= tint_d;
    end
  end

  // Gating with rst_n suppresses the pulse when reset lands in the response cycle.
  assign clint_ready_o     = (state_q == ST_RESP) && rst_n;
  assign clint_data_read_o = clint_ready_o ? rdata_q : 64'd0;
  assign clint_resp_o      = clint_ready_o ? resp_q : 2'b00;
  assign clint_timer_int_o = tint_q;

endmodule
